// File: rtl/serial_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// serial_xfer_ctrl
//
// Purpose:
//   Sequences one serial word transfer with a check. A parallel word and an
//   expected pattern are captured when start is seen in IDLE. The word is then
//   shifted out MSB-first on ser_out while ser_in is shifted into a receive
//   register, one bit per SHIFT cycle, for WIDTH cycles. The received word is
//   compared with the expected pattern in CMP, and DONE gives a one-cycle
//   done pulse.
//
// Handshake (start/busy):
//   start is sampled only while busy is low (IDLE). A start seen at a rising
//   edge in IDLE is accepted at that edge and busy rises for the next cycle.
//   While busy is high, start, tx_data and exp_data are ignored and nothing
//   is queued. done pulses for exactly one cycle and busy falls after it.
//   rx_data/match are updated only in CMP and hold until the next CMP.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   transfer request, sampled in IDLE
//   abort      in   synchronous cancel, effective in SHIFT and CMP
//   tx_data    in   [WIDTH] word to send, captured on accepted start
//   exp_data   in   [WIDTH] expected word, captured on accepted start
//   ser_in     in   serial receive bit, sampled every SHIFT cycle
//   ser_out    out  serial transmit bit (tx MSB during SHIFT, else 0)
//   shift_en   out  high during SHIFT cycles
//   busy       out  high in SHIFT, CMP and DONE
//   done       out  one-cycle pulse in DONE
//   rx_data    out  [WIDTH] last received word
//   match      out  last rx_data == expected word
//   dbg_state  out  [2] current FSM state for observation
// -----------------------------------------------------------------------------
module serial_xfer_ctrl #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] tx_data,
    input  logic [WIDTH-1:0] exp_data,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             match,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CMP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   tx_q, tx_d;
    logic [WIDTH-1:0]   rx_q, rx_d;
    logic [WIDTH-1:0]   exp_q, exp_d;
    logic [WIDTH-1:0]   rx_data_q, rx_data_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            exp_q     <= '0;
            rx_data_q <= '0;
            match_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            exp_q     <= exp_d;
            rx_data_q <= rx_data_d;
            match_q   <= match_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        exp_d     = exp_q;
        rx_data_d = rx_data_q;
        match_d   = match_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                // start beats abort here because abort is not looked at in IDLE
                if (start) begin
                    tx_d    = tx_data;
                    exp_d   = exp_data;
                    rx_d    = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    tx_d  = {tx_q[WIDTH-2:0], 1'b0};
                    rx_d  = {rx_q[WIDTH-2:0], ser_in};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_d = ST_CMP;
                    end
                end
            end
            ST_CMP: begin
                // An abort here leaves the previously reported result intact
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    rx_data_d = rx_q;
                    match_d   = (rx_q == exp_q);
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decodes depend on registers only, never on inputs
    assign shift_en  = (state_q == ST_SHIFT);
    assign ser_out   = (state_q == ST_SHIFT) ? tx_q[WIDTH-1] : 1'b0;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign rx_data   = rx_data_q;
    assign match     = match_q;
    assign dbg_state = state_q;

endmodule

// File: doc/serial_xfer_ctrl.md
Name: serial_xfer_ctrl

Overview:
Sequencer for one serial word transfer with check, built from our shift-register and comparator primitives. It accepts a parallel word and an expected pattern through a start/busy handshake. It shifts the word out MSB-first on a serial line while shifting a serial input into a receive register, then compares the received word with the expected pattern. It reports the result with a one-cycle done pulse and sits between a requester and a serial link or loopback.

Parameters:
WIDTH, 4, bits per transfer; legal range 2..32; sizes tx/rx/exp registers.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, never overridden.

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request a transfer; sampled only in IDLE
abort  input  1  synchronous cancel of an in-flight transfer
tx_data  input  WIDTH  word to send; captured on accepted start
exp_data  input  WIDTH  expected received word; captured on accepted start
ser_in  input  1  serial receive bit; sampled every SHIFT cycle
ser_out  output  1  serial transmit bit; MSB of tx shift register during SHIFT, else 0
shift_en  output  1  high exactly during SHIFT cycles (chip-select for external shifters)
busy  output  1  high in SHIFT, CMP and DONE
done  output  1  one-cycle pulse in DONE
rx_data  output  WIDTH  received word; valid from done, held until next CMP
match  output  1  rx_data == exp_data; valid from done, held until next CMP

Behaviour:
- Reset (rst_n=0, any time, async): state=IDLE; tx_reg, rx_reg, exp_reg, rx_data, bit_cnt=0; match, done, busy, shift_en, ser_out=0.
- States: IDLE, SHIFT, CMP, DONE. Encoding is free; no other reachable states.
- IDLE: start=1 -> tx_reg<=tx_data, exp_reg<=exp_data, rx_reg<=0, bit_cnt<=0, next=SHIFT. start=0 -> stay.
- SHIFT, each cycle:
  - ser_out=tx_reg[WIDTH-1] combinationally from the register.
  - At the edge: tx_reg<={tx_reg[WIDTH-2:0],1'b0}; rx_reg<={rx_reg[WIDTH-2:0],ser_in}; bit_cnt<=bit_cnt+1.
  - When bit_cnt==WIDTH-1 at the edge -> next=CMP.
  - Exactly WIDTH SHIFT cycles per transfer. First bit sent and first bit received are the MSB.
- CMP (1 cycle): rx_data<=rx_reg; match<=(rx_reg==exp_reg); next=DONE.
- DONE (1 cycle): done=1; next=IDLE. A new start is accepted in the following IDLE cycle at the earliest.
- Latency: start accepted at edge T -> SHIFT covers cycles T+1..T+WIDTH -> CMP at T+WIDTH+1 -> done high during cycle T+WIDTH+2.
- Minimum start-to-start spacing: WIDTH+3 cycles.
- start while busy: ignored, not queued; tx_data/exp_data changes while busy have no effect.
- abort=1 in SHIFT or CMP: next=IDLE, no done, rx_data/match keep their previous values. abort in DONE: ignored, done still pulses. abort in IDLE: no effect.
- abort and start both high in IDLE: start wins.
- Only done, busy, shift_en and ser_out are combinational decodes of state/registers. No combinational path from any input to any output.

Test Plan:
- Loopback (ser_in=ser_out), WIDTH=4, tx_data=4'b1011, exp_data=4'b1011, start 1 cycle -> ser_out sequence 1,0,1,1 over 4 shift_en cycles; done 6 cycles after start edge; rx_data=4'b1011, match=1.
- Loopback, tx_data=4'b0110, exp_data=4'b0111 -> rx_data=4'b0110, match=0, done single pulse.
- ser_in driven 1,1,0,0 by bench, tx_data=4'b0000, exp_data=4'b1100 -> ser_out all 0, rx_data=4'b1100, match=1.
- Second start pulsed at cycle 2 of SHIFT, tx_data changed -> ignored; first transfer completes unchanged; busy stays high until DONE, then low.
- abort at 2nd SHIFT cycle after a prior matched transfer -> back to IDLE next cycle, no done; rx_data/match keep prior values; a new start then runs to completion normally.
- rst_n low mid-SHIFT -> all outputs 0 immediately (asynchronously); after release, IDLE; first start gives correct done timing.
